mips_wb_master: RTL and testbench

// - Bridge from the MIPS32r1 core data/instruction memory port to a Wishbone classic master.
// - Sits directly upstream of the wb_ram slave and of the SoC interconnect.
// - Latches one CPU request, runs a single Wishbone cycle and waits for ack/err/timeout.
// - Returns read data with a one-cycle ready pulse; one transaction in flight at a time.

---
 rtl/soc_bus_pkg.sv | 23 ++
 rtl/wb_timeout_ctr.sv | 38 +++
 rtl/mips_wb_master.sv | 147 ++++++++++++++
 tb/tb_mips_wb_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus constants for the MIPS-to-Wishbone bridge: FSM encoding, select mask and timeout defaults.
package soc_bus_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUS  = ST_BUS,
      DONE = ST_DONE
   } wb_state_e;

   localparam logic [3:0]  SEL_ALL          = 4'hF;
   localparam int unsigned TIMEOUT_DEFAULT  = 255;
   localparam int unsigned TO_WIDTH_DEFAULT = 8;

   // Any asserted byte enable counts as a write; otherwise a read level is needed.
   function automatic logic is_request(input logic rd, input logic [3:0] wr);
      return rd || (wr != 4'b0000);
   endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter for bus-cycle timeout; tc flags the last allowed cycle.
module wb_timeout_ctr #(
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TO_WIDTH-1:0] TC_VAL  = TO_WIDTH'(TIMEOUT - 1);
   localparam logic [TO_WIDTH-1:0] MAX_VAL = '1;

   logic [TO_WIDTH-1:0] cnt_d;
   logic [TO_WIDTH-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != MAX_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mips_wb_master.sv
// MIPS32 memory port to Wishbone classic master: one latched request, one bus cycle,
// completion reported by a single-cycle cpu_ready pulse (with bus_err on err/timeout).
module mips_wb_master
   import soc_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
   parameter int unsigned TO_WIDTH   = TO_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-3:0] cpu_addr,
   input  logic                  cpu_read,
   input  logic [3:0]            cpu_write,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  bus_err,
   output logic [ADDR_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic                  we_o,
   output logic [3:0]            sel_o,
   output logic                  stb_o,
   output logic                  cyc_o,
   input  logic                  ack_i,
   input  logic                  err_i
);

   wb_state_e             state_d,  state_q;
   logic [ADDR_WIDTH-1:0] adr_d,    adr_q;
   logic [DATA_WIDTH-1:0] dat_d,    dat_q;
   logic                  we_d,     we_q;
   logic [3:0]            sel_d,    sel_q;
   logic                  cyc_d,    cyc_q;
   logic [DATA_WIDTH-1:0] rdata_d,  rdata_q;
   logic                  ready_d,  ready_q;
   logic                  err_d,    err_q;

   logic ctr_clr;
   logic ctr_en;
   logic ctr_tc;
   logic req;

   assign req = is_request(cpu_read, cpu_write);

   wb_timeout_ctr #(
      .TIMEOUT  (TIMEOUT),
      .TO_WIDTH (TO_WIDTH)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clr),
      .en    (ctr_en),
      .tc    (ctr_tc)
   );

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      sel_d   = sel_q;
      cyc_d   = cyc_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      ctr_clr = 1'b0;
      ctr_en  = 1'b0;

      case (state_q)
         IDLE: begin
            ctr_clr = 1'b1;
            if (req) begin
               state_d = BUS;
               cyc_d   = 1'b1;
               adr_d   = {cpu_addr, 2'b00};
               dat_d   = cpu_wdata;
               // A simultaneous read request is dropped in favour of the write.
               we_d    = |cpu_write;
               sel_d   = (|cpu_write) ? cpu_write : SEL_ALL;
            end
         end
         BUS: begin
            ctr_en = 1'b1;
            if (ack_i) begin
               state_d = DONE;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               rdata_d = we_q ? '0 : dat_i;
            end else if (err_i || ctr_tc) begin
               state_d = DONE;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         DONE: begin
            // Extra dead cycle keeps stb_o low right after ack so the slave re-arms.
            ctr_clr = 1'b1;
            cyc_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= 4'b0000;
         cyc_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign adr_o     = adr_q;
   assign dat_o     = dat_q;
   assign we_o      = we_q;
   assign sel_o     = sel_q;
   assign cyc_o     = cyc_q;
   assign stb_o     = cyc_q;
   assign cpu_rdata = rdata_q;
   assign cpu_ready = ready_q;
   assign bus_err   = err_q;

endmodule

// File: tb/tb_mips_wb_master.sv
// Directed bench for mips_wb_master with a behavioural wb_ram-style slave (ack one cycle after stb).
module tb_mips_wb_master;

   localparam logic [1:0] MODE_ACK  = 2'd0;
   localparam logic [1:0] MODE_NONE = 2'd1;
   localparam logic [1:0] MODE_ERR  = 2'd2;
   localparam logic [1:0] MODE_BOTH = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] cpu_addr;
   logic        cpu_read;
   logic [3:0]  cpu_write;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        bus_err;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        we_o;
   logic [3:0]  sel_o;
   logic        stb_o;
   logic        cyc_o;
   logic        ack_i;
   logic        err_i;

   logic [1:0]  slave_mode = MODE_ACK;
   logic [31:0] mem [0:255];
   logic        init_done = 1'b0;
   logic        cyc_prev = 1'b0;
   int          ack_count = 0;
   int          ready_count = 0;
   int          cyc_starts = 0;

   int n_cmp = 0;
   int n_err = 0;

   // Results of the most recent run_req call.
   logic        r_got;
   int          r_lat;
   int          r_cyc;
   logic [31:0] r_rdata;
   logic        r_berr;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic        r_we;

   always #5 clk = ~clk;

   mips_wb_master #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .TIMEOUT    (8),
      .TO_WIDTH   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .bus_err   (bus_err),
      .adr_o     (adr_o),
      .dat_o     (dat_o),
      .dat_i     (dat_i),
      .we_o      (we_o),
      .sel_o     (sel_o),
      .stb_o     (stb_o),
      .cyc_o     (cyc_o),
      .ack_i     (ack_i),
      .err_i     (err_i)
   );

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] sel);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Slave: registered ack one cycle after stb, never a second response in a row.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_i <= 1'b0;
         err_i <= 1'b0;
         dat_i <= 32'h0;
         if (!init_done) begin
            mem[4]    <= 32'hDEADBEEF;
            init_done <= 1'b1;
         end
      end else begin
         ack_i <= 1'b0;
         err_i <= 1'b0;
         if (cyc_o && stb_o && !ack_i && !err_i) begin
            case (slave_mode)
               MODE_ACK: begin
                  ack_i <= 1'b1;
                  if (we_o) mem[adr_o[9:2]] <= merge_bytes(mem[adr_o[9:2]], dat_o, sel_o);
                  else      dat_i <= mem[adr_o[9:2]];
               end
               MODE_ERR: begin
                  err_i <= 1'b1;
                  dat_i <= 32'h12345678;
               end
               MODE_BOTH: begin
                  ack_i <= 1'b1;
                  err_i <= 1'b1;
                  dat_i <= mem[adr_o[9:2]];
               end
               default: ;
            endcase
         end
      end
   end

   always @(posedge clk) begin
      cyc_prev <= cyc_o;
      if (ack_i) ack_count <= ack_count + 1;
      if (cpu_ready) ready_count <= ready_count + 1;
      if (cyc_o && !cyc_prev) cyc_starts <= cyc_starts + 1;
   end

   // Drive a request at the current negedge and wait (bounded) for cpu_ready.
   task automatic run_req(input logic rd, input logic [3:0] wr, input logic [29:0] addr,
                          input logic [31:0] wd, input logic drop);
      cpu_read  = rd;
      cpu_write = wr;
      cpu_addr  = addr;
      cpu_wdata = wd;
      r_got = 1'b0; r_lat = 0; r_cyc = 0; r_rdata = 32'h0; r_berr = 1'b0;
      r_adr = 32'h0; r_dat = 32'h0; r_sel = 4'h0; r_we = 1'b0;
      for (int i = 0; i < 40 && !r_got; i++) begin
         @(negedge clk);
         r_lat++;
         if (cyc_o) r_cyc++;
         if (r_lat == 1) begin
            r_adr = adr_o; r_dat = dat_o; r_sel = sel_o; r_we = we_o;
         end
         if (cpu_ready) begin
            r_got   = 1'b1;
            r_rdata = cpu_rdata;
            r_berr  = bus_err;
         end
      end
      if (drop) begin
         cpu_read  = 1'b0;
         cpu_write = 4'h0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cpu_read = 1'b0; cpu_write = 4'h0; cpu_addr = 30'h0; cpu_wdata = 32'h0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin n_err++; $display("FAIL reset_ctl: cyc/stb/we=%b expected 000", {cyc_o, stb_o, we_o}); end
      n_cmp++; if ({cpu_ready, bus_err} !== 2'b00) begin n_err++; $display("FAIL reset_ready: ready/err=%b expected 00", {cpu_ready, bus_err}); end
      n_cmp++; if (adr_o !== 32'h0) begin n_err++; $display("FAIL reset_adr: got %h expected 0", adr_o); end
      n_cmp++; if (sel_o !== 4'h0) begin n_err++; $display("FAIL reset_sel: got %h expected 0", sel_o); end
      n_cmp++; if ({dat_o, cpu_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_data: dat_o %h rdata %h expected 0", dat_o, cpu_rdata); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: released");
   endtask

   task automatic test_read();
      slave_mode = MODE_ACK;
      run_req(1'b1, 4'h0, 30'h04, 32'h0, 1'b1);
      $display("read addr=04: got=%0b lat=%0d rdata=%h err=%0b", r_got, r_lat, r_rdata, r_berr);
      n_cmp++; if (r_got !== 1'b1) begin n_err++; $display("FAIL read_done: got %0b expected 1", r_got); end
      n_cmp++; if (r_lat != 3) begin n_err++; $display("FAIL read_latency: got %0d expected 3", r_lat); end
      n_cmp++; if (r_adr !== 32'h10) begin n_err++; $display("FAIL read_adr: got %h expected 00000010", r_adr); end
      n_cmp++; if (r_sel !== 4'hF || r_we !== 1'b0) begin n_err++; $display("FAIL read_sel_we: sel %h we %0b expected F 0", r_sel, r_we); end
      n_cmp++; if (r_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_data: got %h expected deadbeef", r_rdata); end
      n_cmp++; if (r_berr !== 1'b0) begin n_err++; $display("FAIL read_err: got %0b expected 0", r_berr); end
      @(negedge clk);
      n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL read_pulse: ready %0b expected 0 one cycle later", cpu_ready); end
   endtask

   task automatic test_byte_write();
      slave_mode = MODE_ACK;
      // Read is also asserted: the write must win.
      run_req(1'b1, 4'b0010, 30'h04, 32'h0000AB00, 1'b1);
      $display("write addr=04 sel=2: got=%0b we=%0b sel=%h dat=%h rdata=%h", r_got, r_we, r_sel, r_dat, r_rdata);
      n_cmp++; if (r_got !== 1'b1) begin n_err++; $display("FAIL wr_done: got %0b expected 1", r_got); end
      n_cmp++; if (r_sel !== 4'h2 || r_we !== 1'b1) begin n_err++; $display("FAIL wr_sel_we: sel %h we %0b expected 2 1", r_sel, r_we); end
      n_cmp++; if (r_dat !== 32'h0000AB00) begin n_err++; $display("FAIL wr_dat: got %h expected 0000ab00", r_dat); end
      n_cmp++; if (r_rdata !== 32'h0 || r_berr !== 1'b0) begin n_err++; $display("FAIL wr_resp: rdata %h err %0b expected 0 0", r_rdata, r_berr); end
      @(negedge clk);
      run_req(1'b1, 4'h0, 30'h04, 32'h0, 1'b1);
      $display("readback addr=04: rdata=%h", r_rdata);
      n_cmp++; if (r_rdata !== 32'hDEADABEF) begin n_err++; $display("FAIL wr_readback: got %h expected deadabef", r_rdata); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acks0, readies0, starts0;
      logic [29:0] a;
      slave_mode = MODE_ACK;
      acks0 = ack_count; readies0 = ready_count; starts0 = cyc_starts;
      for (int i = 0; i < 8; i++) begin
         a = 30'(32'h20 + i);
         run_req(1'b0, 4'hF, a, 32'hA5A50000 + 32'(i), 1'b0);
         $display("b2b write %0d: got=%0b lat=%0d", i, r_got, r_lat);
         n_cmp++; if (r_got !== 1'b1) begin n_err++; $display("FAIL b2b_wr_done[%0d]: got %0b expected 1", i, r_got); end
      end
      for (int i = 0; i < 8; i++) begin
         a = 30'(32'h20 + i);
         run_req(1'b1, 4'h0, a, 32'h0, i == 7);
         $display("b2b read %0d: got=%0b rdata=%h", i, r_got, r_rdata);
         n_cmp++; if (r_rdata !== 32'hA5A50000 + 32'(i)) begin n_err++; $display("FAIL b2b_rd_data[%0d]: got %h expected %h", i, r_rdata, 32'hA5A50000 + 32'(i)); end
      end
      repeat (3) @(negedge clk);
      $display("b2b counts: acks=%0d readies=%0d cycles=%0d", ack_count - acks0, ready_count - readies0, cyc_starts - starts0);
      n_cmp++; if (ack_count - acks0 != 16) begin n_err++; $display("FAIL b2b_acks: got %0d expected 16", ack_count - acks0); end
      n_cmp++; if (ready_count - readies0 != 16) begin n_err++; $display("FAIL b2b_readies: got %0d expected 16", ready_count - readies0); end
      n_cmp++; if (cyc_starts - starts0 != 16) begin n_err++; $display("FAIL b2b_cycles: got %0d expected 16", cyc_starts - starts0); end
   endtask

   task automatic test_timeout();
      slave_mode = MODE_NONE;
      run_req(1'b1, 4'h0, 30'h05, 32'h0, 1'b1);
      $display("timeout: got=%0b lat=%0d cyc_cycles=%0d err=%0b rdata=%h", r_got, r_lat, r_cyc, r_berr, r_rdata);
      n_cmp++; if (r_got !== 1'b1) begin n_err++; $display("FAIL to_done: got %0b expected 1", r_got); end
      n_cmp++; if (r_cyc != 8) begin n_err++; $display("FAIL to_cyc_len: got %0d expected 8", r_cyc); end
      n_cmp++; if (r_lat != 9) begin n_err++; $display("FAIL to_latency: got %0d expected 9", r_lat); end
      n_cmp++; if (r_berr !== 1'b1 || r_rdata !== 32'h0) begin n_err++; $display("FAIL to_resp: err %0b rdata %h expected 1 0", r_berr, r_rdata); end
      @(negedge clk);
      n_cmp++; if (bus_err !== 1'b0 || cpu_ready !== 1'b0) begin n_err++; $display("FAIL to_pulse: err %0b ready %0b expected 0 0", bus_err, cpu_ready); end
      slave_mode = MODE_ACK;
   endtask

   task automatic test_error();
      slave_mode = MODE_ERR;
      run_req(1'b1, 4'h0, 30'h04, 32'h0, 1'b1);
      $display("err: got=%0b lat=%0d err=%0b rdata=%h", r_got, r_lat, r_berr, r_rdata);
      n_cmp++; if (r_got !== 1'b1 || r_lat != 3) begin n_err++; $display("FAIL err_done: got %0b lat %0d expected 1 3", r_got, r_lat); end
      n_cmp++; if (r_berr !== 1'b1 || r_rdata !== 32'h0) begin n_err++; $display("FAIL err_resp: err %0b rdata %h expected 1 0", r_berr, r_rdata); end
      @(negedge clk);
      slave_mode = MODE_BOTH;
      run_req(1'b1, 4'h0, 30'h04, 32'h0, 1'b1);
      $display("ack+err: got=%0b err=%0b rdata=%h", r_got, r_berr, r_rdata);
      n_cmp++; if (r_got !== 1'b1 || r_berr !== 1'b0) begin n_err++; $display("FAIL both_err: got %0b err %0b expected 1 0", r_got, r_berr); end
      n_cmp++; if (r_rdata !== 32'hDEADABEF) begin n_err++; $display("FAIL both_data: got %h expected deadabef", r_rdata); end
      @(negedge clk);
      slave_mode = MODE_ACK;
   endtask

   task automatic test_async_reset();
      int seen;
      slave_mode = MODE_ACK;
      cpu_read = 1'b1; cpu_write = 4'h0; cpu_addr = 30'h04;
      @(negedge clk);
      n_cmp++; if (stb_o !== 1'b1) begin n_err++; $display("FAIL arst_stb_before: got %0b expected 1", stb_o); end
      #1 rst_n = 1'b0;
      #1;
      $display("async reset mid-cycle: cyc=%0b stb=%0b", cyc_o, stb_o);
      n_cmp++; if ({cyc_o, stb_o} !== 2'b00) begin n_err++; $display("FAIL arst_drop: cyc/stb %b expected 00", {cyc_o, stb_o}); end
      cpu_read = 1'b0;
      seen = 0;
      repeat (2) begin @(negedge clk); if (cpu_ready) seen++; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (cpu_ready) seen++; end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL arst_no_ready: got %0d pulses expected 0", seen); end
      run_req(1'b1, 4'h0, 30'h04, 32'h0, 1'b1);
      $display("post-reset read: got=%0b lat=%0d rdata=%h", r_got, r_lat, r_rdata);
      n_cmp++; if (r_got !== 1'b1 || r_lat != 3) begin n_err++; $display("FAIL arst_fresh: got %0b lat %0d expected 1 3", r_got, r_lat); end
      n_cmp++; if (r_rdata !== 32'hDEADABEF || r_berr !== 1'b0) begin n_err++; $display("FAIL arst_data: rdata %h err %0b expected deadabef 0", r_rdata, r_berr); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read();
      test_byte_write();
      test_back_to_back();
      test_timeout();
      test_error();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
